// File: rtl/seq_timing_unit.sv
`default_nettype none
// ============================================================================
// Module  : seq_timing_unit
// Brief   : T-state sequence counter and datapath strobe decoder with memory
//           wait handling, wait timeout, HALT/resume and register selects.
// Rev     : 1.0  initial release
// ============================================================================
module seq_timing_unit #(
  parameter int DATA_W   = 19,
  parameter int NUM_GPR  = 4,
  parameter int MAX_T    = 8,
  parameter int WAIT_MAX = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DATA_W-1:0]   ir_i,
  input  logic [DATA_W-1:0]   dr_i,
  input  logic [DATA_W-1:0]   ac_i,
  input  logic                mem_ready_i,
  input  logic                resume_i,
  output logic [MAX_T-1:0]    t_o,
  output logic                pc_bus_o,
  output logic                ld_ar_o,
  output logic                ld_pc_o,
  output logic                inc_pc_o,
  output logic                ld_ir_o,
  output logic                ld_dr_o,
  output logic                ld_ac_o,
  output logic                stk_push_o,
  output logic                alu_go_o,
  output logic                mem_rd_o,
  output logic                mem_wr_o,
  output logic [NUM_GPR-1:0]  reg_ld_o,
  output logic [NUM_GPR-1:0]  reg_bus_o,
  output logic                halted_o,
  output logic                timeout_o
);

  localparam int RIDX_W = (NUM_GPR > 1) ? $clog2(NUM_GPR) : 1;
  localparam int SC_W   = $clog2(MAX_T);
  localparam int WC_W   = $clog2(WAIT_MAX + 1);

  localparam logic [2:0] c_op_halt  = 3'd0;
  localparam logic [2:0] c_op_jmp   = 3'd1;
  localparam logic [2:0] c_op_call  = 3'd2;
  localparam logic [2:0] c_op_load  = 3'd3;
  localparam logic [2:0] c_op_store = 3'd4;
  localparam logic [2:0] c_op_beq   = 3'd5;
  localparam logic [2:0] c_op_bne   = 3'd6;
  localparam logic [2:0] c_op_alu   = 3'd7;

  localparam logic [SC_W-1:0] c_t0     = SC_W'(0);
  localparam logic [SC_W-1:0] c_t1     = SC_W'(1);
  localparam logic [SC_W-1:0] c_t2     = SC_W'(2);
  localparam logic [SC_W-1:0] c_t3     = SC_W'(3);
  localparam logic [SC_W-1:0] c_t4     = SC_W'(4);
  localparam logic [SC_W-1:0] c_t5     = SC_W'(5);
  localparam logic [SC_W-1:0] c_t6     = SC_W'(6);
  localparam logic [SC_W-1:0] c_t_last = SC_W'(MAX_T - 1);
  localparam logic [WC_W-1:0] c_wait_max = WC_W'(WAIT_MAX);

  logic [SC_W-1:0]    r_sc, w_sc_nxt;
  logic [WC_W-1:0]    r_wait_cnt, w_wait_nxt;
  logic               r_eq, r_timeout, w_timeout_nxt;
  logic [2:0]         w_op;
  logic [RIDX_W-1:0]  w_idx;
  logic [NUM_GPR-1:0] w_sel;
  logic               w_ir_unused;
  logic               w_rd_req, w_wr_req, w_req, w_expired, w_accept, w_wait;
  logic               w_pc_bus, w_ld_ar, w_ld_pc, w_inc_pc, w_ld_ir, w_ld_dr, w_ld_ac;
  logic               w_push, w_alu, w_reg_ld_en, w_reg_bus_en, w_halt, w_clear;

  assign w_op        = ir_i[DATA_W-1 -: 3];
  assign w_idx       = ir_i[DATA_W-4 -: RIDX_W];
  assign w_ir_unused = ^ir_i;

  // Out-of-range indices match no bit, so the selects come out all-zero.
  for (genvar g = 0; g < NUM_GPR; g++) begin : g_sel
    assign w_sel[g] = (w_idx == RIDX_W'(g));
  end

  assign w_rd_req  = (r_sc == c_t1) || ((r_sc == c_t3) && (w_op == c_op_load));
  assign w_wr_req  = (r_sc == c_t3) && (w_op == c_op_store);
  assign w_req     = w_rd_req || w_wr_req;
  assign w_expired = w_req && (r_wait_cnt == c_wait_max);
  assign w_accept  = w_req && mem_ready_i && !w_expired;
  assign w_wait    = w_req && !mem_ready_i && !w_expired;

  always_comb begin
    w_pc_bus = 1'b0; w_ld_ar = 1'b0; w_ld_pc = 1'b0; w_inc_pc = 1'b0;
    w_ld_ir = 1'b0; w_ld_dr = 1'b0; w_ld_ac = 1'b0; w_push = 1'b0;
    w_alu = 1'b0; w_reg_ld_en = 1'b0; w_reg_bus_en = 1'b0;
    w_halt = 1'b0; w_clear = 1'b0;
    case (r_sc)
      c_t0: begin w_pc_bus = 1'b1; w_ld_ar = 1'b1; end
      c_t1: begin w_ld_ir = w_accept; w_inc_pc = w_accept; end
      c_t2: begin
        if (w_op == c_op_halt)       w_halt  = 1'b1;
        else if (w_op <= c_op_store) w_ld_ar = 1'b1;
      end
      c_t3: begin
        case (w_op)
          c_op_jmp:   begin w_ld_pc = 1'b1; w_clear = 1'b1; end
          c_op_call:  begin w_push = 1'b1; w_pc_bus = 1'b1; end
          c_op_load:  begin w_reg_ld_en = w_accept; w_clear = w_accept; end
          c_op_store: begin w_reg_bus_en = !w_expired; w_clear = w_accept; end
          c_op_beq, c_op_bne: w_ld_dr = 1'b1;
          c_op_alu:   w_alu = 1'b1;
          default: ;
        endcase
      end
      c_t4: begin
        case (w_op)
          c_op_call: begin w_ld_pc = 1'b1; w_clear = 1'b1; end
          c_op_beq, c_op_bne: w_ld_ac = 1'b1;
          c_op_alu:  begin w_reg_ld_en = 1'b1; w_clear = 1'b1; end
          default: ;
        endcase
      end
      c_t6: begin
        if (w_op == c_op_beq)      begin w_ld_pc = r_eq;  w_clear = 1'b1; end
        else if (w_op == c_op_bne) begin w_ld_pc = !r_eq; w_clear = 1'b1; end
      end
      default: ;
    endcase
  end

  always_comb begin
    w_sc_nxt      = r_sc + 1'b1;
    w_wait_nxt    = '0;
    w_timeout_nxt = r_timeout;
    if (w_halt) begin
      w_sc_nxt = r_sc;
      if (resume_i) begin
        w_sc_nxt      = c_t0;
        w_timeout_nxt = 1'b0;
      end
    end else if (w_expired) begin
      w_sc_nxt = c_t0;
    end else if (w_wait) begin
      w_sc_nxt   = r_sc;
      w_wait_nxt = r_wait_cnt + 1'b1;
      if (w_wait_nxt == c_wait_max) w_timeout_nxt = 1'b1;
    end else if (w_clear) begin
      w_sc_nxt = c_t0;
    end else if (r_sc == c_t_last) begin
      // Running off the end of the T-states means a malformed sequence.
      w_sc_nxt      = c_t0;
      w_timeout_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sc       <= c_t0;
      r_wait_cnt <= '0;
      r_eq       <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_sc       <= w_sc_nxt;
      r_wait_cnt <= w_wait_nxt;
      r_timeout  <= w_timeout_nxt;
      if ((r_sc == c_t5) && ((w_op == c_op_beq) || (w_op == c_op_bne)))
        r_eq <= (dr_i == ac_i);
    end
  end

  // T0 decodes to active strobes, so reset must mask them combinationally.
  assign t_o        = MAX_T'(1) << r_sc;
  assign pc_bus_o   = rst_n & w_pc_bus;
  assign ld_ar_o    = rst_n & w_ld_ar;
  assign ld_pc_o    = rst_n & w_ld_pc;
  assign inc_pc_o   = rst_n & w_inc_pc;
  assign ld_ir_o    = rst_n & w_ld_ir;
  assign ld_dr_o    = rst_n & w_ld_dr;
  assign ld_ac_o    = rst_n & w_ld_ac;
  assign stk_push_o = rst_n & w_push;
  assign alu_go_o   = rst_n & w_alu;
  assign mem_rd_o   = rst_n & w_rd_req & !w_expired;
  assign mem_wr_o   = rst_n & w_wr_req & !w_expired;
  assign reg_ld_o   = {NUM_GPR{rst_n & w_reg_ld_en}} & w_sel;
  assign reg_bus_o  = {NUM_GPR{rst_n & w_reg_bus_en}} & w_sel;
  assign halted_o   = rst_n & w_halt;
  assign timeout_o  = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_seq_timing_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_seq_timing_unit
// Brief   : Vector table, directed corner sequences and randomized run against
//           an instruction-level reference model of seq_timing_unit.
// Rev     : 1.0  initial release
// ============================================================================
module tb_seq_timing_unit;

  localparam int DATA_W   = 19;
  localparam int NUM_GPR  = 4;
  localparam int MAX_T    = 8;
  localparam int WAIT_MAX = 15;
  localparam int OUT_W    = MAX_T + 21;

  localparam logic [20:0] S_PCBUS = 21'd1 << 20;
  localparam logic [20:0] S_LDAR  = 21'd1 << 19;
  localparam logic [20:0] S_LDPC  = 21'd1 << 18;
  localparam logic [20:0] S_INCPC = 21'd1 << 17;
  localparam logic [20:0] S_LDIR  = 21'd1 << 16;
  localparam logic [20:0] S_LDDR  = 21'd1 << 15;
  localparam logic [20:0] S_LDAC  = 21'd1 << 14;
  localparam logic [20:0] S_PUSH  = 21'd1 << 13;
  localparam logic [20:0] S_ALU   = 21'd1 << 12;
  localparam logic [20:0] S_RD    = 21'd1 << 11;
  localparam logic [20:0] S_WR    = 21'd1 << 10;
  localparam logic [20:0] S_HALT  = 21'd1 << 1;
  localparam logic [20:0] S_TO    = 21'd1;
  localparam logic [18:0] ONES    = 19'h7FFFF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [DATA_W-1:0] ir, dr, ac;
  logic mem_ready, resume;
  logic [MAX_T-1:0] t_o;
  logic pc_bus, ld_ar, ld_pc, inc_pc, ld_ir, ld_dr, ld_ac, stk_push, alu_go;
  logic mem_rd, mem_wr, halted, timeout;
  logic [NUM_GPR-1:0] reg_ld, reg_bus;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  int m_t, m_wait;
  bit m_to, m_eq;

  always #5 clk = ~clk;

  seq_timing_unit #(.DATA_W(DATA_W), .NUM_GPR(NUM_GPR), .MAX_T(MAX_T), .WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .ir_i(ir), .dr_i(dr), .ac_i(ac),
    .mem_ready_i(mem_ready), .resume_i(resume), .t_o(t_o),
    .pc_bus_o(pc_bus), .ld_ar_o(ld_ar), .ld_pc_o(ld_pc), .inc_pc_o(inc_pc),
    .ld_ir_o(ld_ir), .ld_dr_o(ld_dr), .ld_ac_o(ld_ac), .stk_push_o(stk_push),
    .alu_go_o(alu_go), .mem_rd_o(mem_rd), .mem_wr_o(mem_wr),
    .reg_ld_o(reg_ld), .reg_bus_o(reg_bus), .halted_o(halted), .timeout_o(timeout)
  );

  typedef struct {
    logic [18:0] ir;
    logic [18:0] dr;
    logic [18:0] ac;
    logic        rdy;
    logic        res;
    int          t;
    logic [20:0] s;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [20:0] rl(int i);
    return 21'd1 << (6 + i);
  endfunction

  function automatic logic [20:0] rb(int i);
    return 21'd1 << (2 + i);
  endfunction

  function automatic logic [18:0] mk_ir(int op, int idx);
    return 19'((op << 16) | (idx << 14));
  endfunction

  function automatic logic [OUT_W-1:0] mkexp(int t, logic [20:0] s);
    logic [MAX_T-1:0] oh;
    oh = 8'd1 << t;
    return {oh, s};
  endfunction

  function automatic logic [OUT_W-1:0] actual();
    return {t_o, pc_bus, ld_ar, ld_pc, inc_pc, ld_ir, ld_dr, ld_ac, stk_push, alu_go,
            mem_rd, mem_wr, reg_ld, reg_bus, halted, timeout};
  endfunction

  task automatic check(input string name, input logic [OUT_W-1:0] exp);
    logic [OUT_W-1:0] act;
    act = actual();
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Called at posedge+1: drive, check mid-cycle, advance to next posedge+1.
  task automatic step(input logic [18:0] ir_v, input logic [18:0] dr_v, input logic [18:0] ac_v,
                      input logic rdy_v, input logic res_v, input logic [OUT_W-1:0] exp,
                      input string name);
    ir = ir_v; dr = dr_v; ac = ac_v; mem_ready = rdy_v; resume = res_v;
    #3;
    check(name, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [18:0] ir_v, input logic [18:0] dv, input logic [18:0] av,
                     input int t, input logic [20:0] s);
    vec_t v;
    v.ir = ir_v; v.dr = dv; v.ac = av; v.rdy = 1'b1; v.res = 1'b0; v.t = t; v.s = s;
    tbl.push_back(v);
  endtask

  // Expected outputs for one cycle, from the instruction's step list.
  function automatic logic [OUT_W-1:0] model_out(logic [18:0] irv, logic rdy);
    int op  = int'(irv[18:16]);
    int idx = int'(irv[15:14]);
    logic [20:0] s   = '0;
    logic [20:0] acc = '0;
    bit mem = 0;
    bit wr  = 0;
    case (m_t)
      0: s = S_PCBUS | S_LDAR;
      1: begin mem = 1; acc = S_LDIR | S_INCPC; end
      2: if (op == 0) s = S_HALT; else if (op <= 4) s = S_LDAR;
      3: case (op)
           1: s = S_LDPC;
           2: s = S_PUSH | S_PCBUS;
           3: begin mem = 1; acc = rl(idx); end
           4: begin mem = 1; wr = 1; end
           5, 6: s = S_LDDR;
           7: s = S_ALU;
           default: ;
         endcase
      4: case (op)
           2: s = S_LDPC;
           5, 6: s = S_LDAC;
           7: s = rl(idx);
           default: ;
         endcase
      6: if ((op == 5 && m_eq) || (op == 6 && !m_eq)) s = S_LDPC;
      default: ;
    endcase
    if (mem && m_wait < WAIT_MAX) begin
      s = wr ? (S_WR | rb(idx)) : S_RD;
      if (rdy) s = s | acc;
    end
    if (m_to) s = s | S_TO;
    return mkexp(m_t, s);
  endfunction

  task automatic model_step(input logic [18:0] irv, input logic [18:0] dv, input logic [18:0] av,
                            input logic rdy, input logic res);
    int op = int'(irv[18:16]);
    int last;
    bit mem;
    mem  = (m_t == 1) || (m_t == 3 && (op == 3 || op == 4));
    last = (op == 1) ? 3 : (op == 2) ? 4 : (op == 3 || op == 4) ? 3 :
           (op == 5 || op == 6) ? 6 : (op == 7) ? 4 : 99;
    if (m_t == 2 && op == 0) begin
      if (res) begin m_t = 0; m_to = 0; end
    end else if (mem) begin
      if (m_wait == WAIT_MAX) begin
        m_t = 0; m_wait = 0;
      end else if (!rdy) begin
        m_wait++;
        if (m_wait == WAIT_MAX) m_to = 1;
      end else begin
        m_wait = 0;
        m_t = (m_t == 1) ? 2 : 0;
      end
    end else begin
      if (m_t == 5 && (op == 5 || op == 6)) m_eq = (dv == av);
      if (m_t == last)              m_t = 0;
      else if (m_t == MAX_T - 1)    begin m_t = 0; m_to = 1; end
      else                          m_t++;
    end
  endtask

  initial begin
    logic [18:0] cir, rir, rdv, rav;
    logic rrdy, rres;
    bit stall;
    logic [OUT_W-1:0] e;

    ir = '0; dr = '0; ac = '0; mem_ready = 1'b0; resume = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset", mkexp(0, '0));
    rst_n = 1'b1;

    // JMP, CALL, BEQ, BNE, ALU with memory always ready
    add(mk_ir(1,0), 0, 0, 0, S_PCBUS | S_LDAR);
    add(mk_ir(1,0), 0, 0, 1, S_RD | S_LDIR | S_INCPC);
    add(mk_ir(1,0), 0, 0, 2, S_LDAR);
    add(mk_ir(1,0), 0, 0, 3, S_LDPC);
    add(mk_ir(2,0), 0, 0, 0, S_PCBUS | S_LDAR);
    add(mk_ir(2,0), 0, 0, 1, S_RD | S_LDIR | S_INCPC);
    add(mk_ir(2,0), 0, 0, 2, S_LDAR);
    add(mk_ir(2,0), 0, 0, 3, S_PUSH | S_PCBUS);
    add(mk_ir(2,0), 0, 0, 4, S_LDPC);
    for (int b = 5; b <= 6; b++) begin
      add(mk_ir(b,0), ONES, ONES, 0, S_PCBUS | S_LDAR);
      add(mk_ir(b,0), ONES, ONES, 1, S_RD | S_LDIR | S_INCPC);
      add(mk_ir(b,0), ONES, ONES, 2, '0);
      add(mk_ir(b,0), ONES, ONES, 3, S_LDDR);
      add(mk_ir(b,0), ONES, ONES, 4, S_LDAC);
      add(mk_ir(b,0), ONES, ONES, 5, '0);
      add(mk_ir(b,0), ONES, ONES, 6, (b == 5) ? S_LDPC : 21'd0);
    end
    add(mk_ir(7,1), 0, 0, 0, S_PCBUS | S_LDAR);
    add(mk_ir(7,1), 0, 0, 1, S_RD | S_LDIR | S_INCPC);
    add(mk_ir(7,1), 0, 0, 2, '0);
    add(mk_ir(7,1), 0, 0, 3, S_ALU);
    add(mk_ir(7,1), 0, 0, 4, rl(1));
    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i].ir, tbl[i].dr, tbl[i].ac, tbl[i].rdy, tbl[i].res,
           mkexp(tbl[i].t, tbl[i].s), $sformatf("tbl%0d", i));

    // LOAD idx 2 with three wait cycles at T3
    cir = mk_ir(3,2);
    step(cir, 0, 0, 1, 0, mkexp(0, S_PCBUS | S_LDAR), "load_t0");
    step(cir, 0, 0, 1, 0, mkexp(1, S_RD | S_LDIR | S_INCPC), "load_t1");
    step(cir, 0, 0, 1, 0, mkexp(2, S_LDAR), "load_t2");
    for (int i = 0; i < 3; i++) step(cir, 0, 0, 0, 0, mkexp(3, S_RD), "load_wait");
    step(cir, 0, 0, 1, 0, mkexp(3, S_RD | rl(2)), "load_accept");

    // fetch timeout at T1
    cir = mk_ir(1,0);
    step(cir, 0, 0, 1, 0, mkexp(0, S_PCBUS | S_LDAR), "to_t0");
    for (int i = 0; i < WAIT_MAX; i++) step(cir, 0, 0, 0, 0, mkexp(1, S_RD), "to_wait");
    step(cir, 0, 0, 0, 0, mkexp(1, S_TO), "to_drop");

    // HALT for ten cycles, resume clears timeout
    cir = mk_ir(0,0);
    step(cir, 0, 0, 1, 0, mkexp(0, S_PCBUS | S_LDAR | S_TO), "halt_t0_sticky");
    step(cir, 0, 0, 1, 0, mkexp(1, S_RD | S_LDIR | S_INCPC | S_TO), "halt_t1");
    for (int i = 0; i < 10; i++) step(cir, 0, 0, i[0], 0, mkexp(2, S_HALT | S_TO), "halt_hold");
    step(cir, 0, 0, 0, 1, mkexp(2, S_HALT | S_TO), "halt_resume");

    // STORE idx 3 interrupted by asynchronous reset mid-wait
    cir = mk_ir(4,3);
    step(cir, 0, 0, 1, 0, mkexp(0, S_PCBUS | S_LDAR), "store_t0");
    step(cir, 0, 0, 1, 0, mkexp(1, S_RD | S_LDIR | S_INCPC), "store_t1");
    step(cir, 0, 0, 1, 0, mkexp(2, S_LDAR), "store_t2");
    for (int i = 0; i < 2; i++) step(cir, 0, 0, 0, 0, mkexp(3, S_WR | rb(3)), "store_wait");
    mem_ready = 1'b0;
    #1;
    check("store_wait_pre_reset", mkexp(3, S_WR | rb(3)));
    #1;
    rst_n = 1'b0;
    #1;
    check("store_async_reset", mkexp(0, '0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // randomized run against the reference model
    m_t = 0; m_wait = 0; m_to = 0; m_eq = 0;
    cir = '0;
    stall = 0;
    for (int c = 0; c < 800; c++) begin
      if (m_t == 0) begin
        rir = 19'($urandom);
        rir[18:16] = ($urandom_range(0, 11) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
        cir = rir;
        stall = ($urandom_range(0, 11) == 0);
      end
      rrdy = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
      rres = ($urandom_range(0, 3) == 0);
      rdv  = 19'($urandom);
      rav  = ($urandom_range(0, 1) == 0) ? rdv : 19'($urandom);
      e = model_out(cir, rrdy);
      step(cir, rdv, rav, rrdy, rres, e, "random");
      model_step(cir, rdv, rav, rrdy, rres);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seq_timing_unit.md
SEQ_TIMING_UNIT -- requirements
Module: seq_timing_unit

Interface
REQ-001 Parameter DATA_W, default 19, width of instruction, DR and AC words.
REQ-002 Parameter NUM_GPR, default 4, general registers addressed; RIDX_W = clog2(NUM_GPR), minimum 1.
REQ-003 Parameter MAX_T, default 8, timing states T0..T(MAX_T-1); legal range 7..16.
REQ-004 Parameter WAIT_MAX, default 15, maximum memory wait cycles per access; legal range 1..255.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 rst_n  in  1  reset, asynchronous and active-low.
REQ-007 ir_i  in  DATA_W  instruction register contents; opcode = ir_i[DATA_W-1:DATA_W-3], register index = ir_i[DATA_W-4 -: RIDX_W].
REQ-008 dr_i, ac_i  in  DATA_W each  operands for branch compare.
REQ-009 mem_ready_i  in  1  memory completes the current read/write this cycle.
REQ-010 resume_i  in  1  leave HALT.
REQ-011 t_o  out  MAX_T  one-hot current timing state.
REQ-012 pc_bus_o, ld_ar_o, ld_pc_o, inc_pc_o, ld_ir_o, ld_dr_o, ld_ac_o, stk_push_o, alu_go_o  out  1 each  datapath strobes.
REQ-013 mem_rd_o, mem_wr_o  out  1 each  memory requests, held until accepted.
REQ-014 reg_ld_o, reg_bus_o  out  NUM_GPR each  one-hot register load and bus-drive selects.
REQ-015 halted_o, timeout_o  out  1 each  status: in HALT; sticky memory-timeout flag.

Function
REQ-016 Sequence counter sc SHALL advance by one per cycle unless held or cleared; t_o SHALL be the one-hot decode of sc.
REQ-017 T0: pc_bus_o=1, ld_ar_o=1.
REQ-018 T1: mem_rd_o=1; in the cycle mem_ready_i=1, ld_ir_o=1 and inc_pc_o=1.
REQ-019 T2: opcode 0 -> enter HALT, halted_o=1; opcodes 1-4 -> ld_ar_o=1; opcodes 5-7 -> no strobe.
REQ-020 Opcode 1 (JMP): T3 ld_pc_o=1, clear sc.
REQ-021 Opcode 2 (CALL): T3 stk_push_o=1, pc_bus_o=1; T4 ld_pc_o=1, clear sc.
REQ-022 Opcode 3 (LOAD): T3 mem_rd_o=1; on accept reg_ld_o[idx]=1, clear sc.
REQ-023 Opcode 4 (STORE): T3 mem_wr_o=1, reg_bus_o[idx]=1 held through wait; on accept clear sc.
REQ-024 Opcodes 5/6 (BEQ/BNE): T3 ld_dr_o=1; T4 ld_ac_o=1; T5 register eq_q = (dr_i == ac_i) over all DATA_W bits; T6 ld_pc_o=1 if (op5 and eq_q) or (op6 and not eq_q); clear sc.
REQ-025 Opcode 7 (ALU): T3 alu_go_o=1; T4 reg_ld_o[idx]=1, clear sc.
REQ-026 Clearing sc SHALL place T0 in the next cycle.
REQ-027 Memory wait: while mem_rd_o or mem_wr_o is asserted and mem_ready_i=0, sc SHALL hold and an internal wait counter SHALL increment; other strobes SHALL stay 0 except held reg_bus_o.
REQ-028 Wait counter SHALL clear on accept or on any sc change.
REQ-029 When the wait counter reaches WAIT_MAX with mem_ready_i still 0, timeout_o SHALL set (sticky), the request SHALL drop, and sc SHALL go to T0 next cycle.
REQ-030 If sc reaches T(MAX_T-1) without a clear, sc SHALL wrap to T0 and timeout_o SHALL set.
REQ-031 Register index >= NUM_GPR SHALL produce all-zero reg_ld_o/reg_bus_o; sequencing SHALL be unchanged.
REQ-032 HALT: sc frozen at T2; all strobes 0; resume_i=1 -> T0 next cycle, halted_o=0; timeout_o SHALL clear on resume.
REQ-033 Every strobe SHALL be a registered-state decode valid in the same cycle as its t_o bit; at most one bit of reg_ld_o and one of reg_bus_o SHALL be set.

Reset
REQ-034 rst_n=0 SHALL immediately force sc=T0 (t_o=1), eq_q=0, wait counter=0, halted_o=0, timeout_o=0, and all strobes, mem_rd_o, mem_wr_o, reg_ld_o and reg_bus_o to 0, including mid-wait and mid-instruction.
REQ-035 First rising edge after rst_n rises SHALL execute T0.

Verification
REQ-036 JMP, mem_ready_i=1: t_o 0x01,0x02,0x04,0x08,0x01; ld_pc_o high only in T3.
REQ-037 LOAD idx 2, mem_ready_i low 3 cycles at T3: sc held 3 cycles, then reg_ld_o=4'b0100 for one cycle, then T0.
REQ-038 BEQ with dr_i=ac_i=19'h7FFFF: ld_pc_o=1 at T6; BNE with the same operands: ld_pc_o=0 at T6; both return to T0.
REQ-039 mem_ready_i held 0 at T1 with WAIT_MAX=15: after 15 wait cycles timeout_o=1, mem_rd_o=0, then T0.
REQ-040 Opcode 0: halted_o=1 with no strobes for 10 cycles; resume_i pulse -> T0 next cycle.
REQ-041 rst_n low during a STORE wait: mem_wr_o and reg_bus_o drop asynchronously, t_o=1.
